// File: rtl/cargador_programa.sv
// Boot-time program loader: packs a big-endian byte stream into 32-bit words,
// writes them into instruction memory and holds the core in reset until done.
module cargador_programa #(
    parameter int WORDS  = 64,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [6:0]        num_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [6:0]       nwords_q, nwords_d;
    logic [31:0]      word_q, word_d;

    logic             start_legal;
    logic             last_word;
    logic             byte_hs;
    logic [ADDR_W-1:0] word_addr;

    // A word count of zero or beyond memory capacity cannot be loaded.
    assign start_legal = (num_words != 7'd0) && (int'(num_words) <= WORDS);

    // Final word of the load is the one at index num_words-1.
    assign last_word = (7'(word_idx_q) == (nwords_q - 7'd1));

    assign byte_hs   = byte_valid && (state_q == S_RECV);

    // Word index scaled to a word-aligned byte address.
    assign word_addr = ADDR_W'({word_idx_q, 2'b00});

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            word_idx_q <= '0;
            nwords_q   <= 7'd0;
            word_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            nwords_q   <= nwords_d;
            word_q     <= word_d;
        end
    end

    // Next-state logic: start handling, byte packing and word sequencing.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        nwords_d   = nwords_q;
        word_d     = word_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    if (start_legal) begin
                        nwords_d   = num_words;
                        byte_cnt_d = 2'd0;
                        word_idx_d = '0;
                        state_d    = S_RECV;
                    end else begin
                        state_d    = S_ERR;
                    end
                end
            end
            S_RECV: begin
                if (byte_hs) begin
                    word_d     = {word_q[23:0], byte_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (last_word) begin
                    state_d    = S_DONE;
                end else begin
                    word_idx_d = word_idx_q + 1'b1;
                    state_d    = S_RECV;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode purely from registered state and datapath.
    always_comb begin
        byte_ready = 1'b0;
        im_we      = 1'b0;
        im_addr    = '0;
        im_wdata   = 32'd0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_reset  = 1'b1;
        unique case (state_q)
            S_RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            S_WRITE: begin
                im_we      = 1'b1;
                im_addr    = word_addr;
                im_wdata   = word_q;
                busy       = 1'b1;
            end
            S_DONE: begin
                done       = 1'b1;
                cpu_reset  = 1'b0;
            end
            S_ERR: begin
                error      = 1'b1;
            end
            default: begin
                byte_ready = 1'b0;
            end
        endcase
    end

endmodule
